// File: rtl/and_arb_pkg.sv
// Shared types and defaults for the two-requester arbiter that fronts the
// external and_custom datapath.
package and_arb_pkg;

   localparam int DEF_MAX_OPS = 16;
   localparam int DEF_CNT_W   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } arb_state_t;

   // Round-robin pick: on contention favour whoever was not granted last.
   function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
      return (v0 & v1) ? ~last : v1;
   endfunction

endpackage

// File: rtl/and_gate_arbiter.sv
// Round-robin arbiter sharing one external AND datapath between two
// requesters; stops accepting work after MAX_OPS completed operations.
module and_gate_arbiter
   import and_arb_pkg::*;
#(
   parameter int MAX_OPS = DEF_MAX_OPS,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             test_clock,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic             req0_a,
   input  logic             req0_b,
   output logic             req0_ready,
   output logic             rsp0_valid,
   output logic             rsp0_s,
   input  logic             req1_valid,
   input  logic             req1_a,
   input  logic             req1_b,
   output logic             req1_ready,
   output logic             rsp1_valid,
   output logic             rsp1_s,
   output logic             gate_a,
   output logic             gate_b,
   input  logic             gate_s,
   output logic [CNT_W-1:0] op_count,
   output logic             done
);

   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_OPS);

   arb_state_t       r_state;
   logic             r_last;
   logic             r_id;
   logic             r_a;
   logic             r_b;
   logic             r_res;
   logic [CNT_W-1:0] r_count;

   logic             w_any;
   logic             w_pick;
   logic             w_grant;
   logic             w_exec;
   logic             w_resp;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Every strobe is masked by reset so nothing leaks out while it is held.
   always_comb begin
      w_any      = req0_valid | req1_valid;
      w_pick     = rr_pick(req0_valid, req1_valid, r_last);
      w_grant    = (r_state == IDLE) && w_any && !reset;
      w_exec     = (r_state == EXEC) && !reset;
      w_resp     = (r_state == RESP) && !reset;
      w_cnt_nxt  = r_count + CNT_W'(1);

      req0_ready = w_grant & ~w_pick;
      req1_ready = w_grant &  w_pick;
      gate_a     = w_exec & r_a;
      gate_b     = w_exec & r_b;
      rsp0_valid = w_resp & ~r_id;
      rsp1_valid = w_resp &  r_id;
      rsp0_s     = rsp0_valid & r_res;
      rsp1_s     = rsp1_valid & r_res;
      op_count   = r_count;
      done       = (r_state == DONE);
   end

   always_ff @(posedge test_clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_id    <= 1'b0;
         r_a     <= 1'b0;
         r_b     <= 1'b0;
         r_res   <= 1'b0;
         r_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_id    <= w_pick;
                  r_last  <= w_pick;
                  r_a     <= w_pick ? req1_a : req0_a;
                  r_b     <= w_pick ? req1_b : req0_b;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_res   <= gate_s;
               r_state <= RESP;
            end
            RESP: begin
               r_count <= w_cnt_nxt;
               r_state <= (w_cnt_nxt == LP_MAX) ? DONE : IDLE;
            end
            DONE: r_state <= DONE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_and_gate_arbiter.sv
// Scoreboard bench: a cycle-level reference model predicts grants and pushes
// expected responses; an independent monitor pops them as responses appear.
module tb_and_gate_arbiter;

   localparam int MAX_OPS = 16;
   localparam int CNT_W   = 5;

   logic             test_clock = 1'b0;
   logic             reset = 1'b1;
   logic             req0_valid = 1'b0, req0_a = 1'b0, req0_b = 1'b0;
   logic             req1_valid = 1'b0, req1_a = 1'b0, req1_b = 1'b0;
   logic             req0_ready, rsp0_valid, rsp0_s;
   logic             req1_ready, rsp1_valid, rsp1_s;
   logic             gate_a, gate_b, gate_s;
   logic [CNT_W-1:0] op_count;
   logic             done;

   and_gate_arbiter #(.MAX_OPS(MAX_OPS), .CNT_W(CNT_W)) dut (
      .test_clock(test_clock), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_s(rsp0_s),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_s(rsp1_s),
      .gate_a(gate_a), .gate_b(gate_b), .gate_s(gate_s),
      .op_count(op_count), .done(done)
   );

   // Ideal and_custom next to the arbiter
   assign gate_s = gate_a & gate_b;

   always #5 test_clock = ~test_clock;

   int cyc = 0;
   always @(posedge test_clock) cyc <= cyc + 1;

   int chk = 0;
   int nfail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   typedef struct { int due; bit s; } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   // Reference model: after an accept the datapath is busy for two more
   // cycles, then the op completes and the next accept is possible.
   int m_busy = 0;
   int m_count = 0;
   bit m_last = 1'b1;
   bit m_done = 1'b0;
   bit m_pa, m_pb;
   bit m_acc0 = 1'b0, m_acc1 = 1'b0;

   always @(negedge test_clock) begin : model
      bit v0, v1, can, w;
      exp_t e;
      m_acc0 = 1'b0;
      m_acc1 = 1'b0;
      if (reset) begin
         check("rst_rdy0", 32'(req0_ready), 0);
         check("rst_rdy1", 32'(req1_ready), 0);
         check("rst_rsp0v", 32'(rsp0_valid), 0);
         check("rst_rsp1v", 32'(rsp1_valid), 0);
         check("rst_rsp_s", 32'(rsp0_s | rsp1_s), 0);
         check("rst_gate", 32'({gate_a, gate_b}), 0);
         q0.delete();
         q1.delete();
         m_busy = 0; m_count = 0; m_last = 1'b1; m_done = 1'b0;
      end else begin
         v0  = (req0_valid === 1'b1);
         v1  = (req1_valid === 1'b1);
         can = (m_busy == 0) && !m_done && (v0 || v1);
         w   = (v0 && v1) ? !m_last : v1;
         check("ready0", 32'(req0_ready), 32'(can && !w));
         check("ready1", 32'(req1_ready), 32'(can && w));
         check("gate_a", 32'(gate_a), (m_busy == 2) ? 32'(m_pa) : 0);
         check("gate_b", 32'(gate_b), (m_busy == 2) ? 32'(m_pb) : 0);
         check("op_count", 32'(op_count), m_count);
         check("done", 32'(done), 32'(m_done));
         if (can) begin
            m_pa  = w ? req1_a : req0_a;
            m_pb  = w ? req1_b : req0_b;
            e.due = cyc + 2;
            e.s   = m_pa & m_pb;
            if (w) begin q1.push_back(e); m_acc1 = 1'b1; end
            else   begin q0.push_back(e); m_acc0 = 1'b1; end
            m_last = w;
            m_busy = 2;
         end else if (m_busy == 2) begin
            m_busy = 1;
         end else if (m_busy == 1) begin
            m_busy  = 0;
            m_count = m_count + 1;
            if (m_count == MAX_OPS) m_done = 1'b1;
         end
      end
   end

   always @(negedge test_clock) begin : monitor
      exp_t e;
      if (!reset) begin
         if (q0.size() > 0 && q0[0].due < cyc) begin
            e = q0.pop_front();
            check("rsp0_missing_at", cyc, e.due);
         end
         if (q1.size() > 0 && q1[0].due < cyc) begin
            e = q1.pop_front();
            check("rsp1_missing_at", cyc, e.due);
         end
         if (rsp0_valid === 1'b1) begin
            if (q0.size() == 0) check("rsp0_unexpected", 32'(rsp0_valid), 0);
            else begin
               e = q0.pop_front();
               check("rsp0_cycle", cyc, e.due);
               check("rsp0_s", 32'(rsp0_s), 32'(e.s));
            end
         end
         if (rsp1_valid === 1'b1) begin
            if (q1.size() == 0) check("rsp1_unexpected", 32'(rsp1_valid), 0);
            else begin
               e = q1.pop_front();
               check("rsp1_cycle", cyc, e.due);
               check("rsp1_s", 32'(rsp1_s), 32'(e.s));
            end
         end
      end
   end

   task automatic tick();
      @(posedge test_clock);
      #1;
   endtask

   task automatic issue(input bit id, input bit a, input bit b);
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      for (int k = 0; k < 40; k++) begin
         tick();
         if (id ? m_acc1 : m_acc0) break;
      end
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   initial begin
      int acc;
      logic [1:0] pairs [4];
      pairs[0] = 2'b00; pairs[1] = 2'b01; pairs[2] = 2'b10; pairs[3] = 2'b11;
      do_reset(3);

      // Single request with 1,1
      issue(1'b0, 1'b1, 1'b1);
      repeat (3) tick();

      // Requester 1 walks the truth table
      for (int i = 0; i < 4; i++) issue(1'b1, pairs[i][1], pairs[i][0]);
      repeat (3) tick();

      // Both held high: alternating grants
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 1'($urandom); req0_b = 1'($urandom);
      req1_a = 1'($urandom); req1_b = 1'($urandom);
      acc = 0;
      for (int k = 0; k < 60 && acc < 8; k++) begin
         tick();
         if (m_acc0) begin acc++; req0_a = 1'($urandom); req0_b = 1'($urandom); end
         if (m_acc1) begin acc++; req1_a = 1'($urandom); req1_b = 1'($urandom); end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) tick();

      // Reset during EXEC drops the op; next contention goes to requester 0
      issue(1'b1, 1'b1, 1'b1);
      do_reset(1);
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 1'b1; req0_b = 1'b0; req1_a = 1'b1; req1_b = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (m_acc0 || m_acc1) break;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (4) tick();

      // Fresh run to the op limit with mostly back-to-back random traffic
      do_reset(2);
      for (int k = 0; k < 400 && !m_done; k++) begin
         req0_valid = ($urandom_range(0, 7) != 0);
         req1_valid = ($urandom_range(0, 7) != 0);
         req0_a = 1'($urandom); req0_b = 1'($urandom);
         req1_a = 1'($urandom); req1_b = 1'($urandom);
         tick();
      end
      check("done_reached", 32'(done), 1);
      check("final_count", 32'(op_count), MAX_OPS);
      req0_valid = 1'b1; req1_valid = 1'b1;
      repeat (12) tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) tick();
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("%0d/%0d checks passed", chk - nfail, chk);
      $finish;
   end

endmodule
